nash_core_xp: RTL and testbench
===============================

Name: nash_core_xp

Overview:
- Parametrised successor to the fixed 8-state Nash cipher core.
- Implements a Nash-style two-path (red/blue) permutation machine with a configurable state count and a configurable history depth.
- Tables are loaded through a per-entry config write port, and the block XORs the generated keystream with the data stream.
- Supports encrypt and decrypt modes with self-synchronising ciphertext feedback, and uses valid/ready handshakes with a registered output; it sits between the bit-serial framer and the link interface.

Parameters:
- NUM_STATES, 8, number of machine states (2..16); states are numbered 0..NUM_STATES-1.
- STATE_W, 4, width of a state index; must satisfy 2^STATE_W >= NUM_STATES.
- HIST_DEPTH, 8, history shift-register length; must be >= NUM_STATES.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; synchronous, active-low.
- cfg_we  in  1  write one table entry
- cfg_addr  in  STATE_W  entry index
- cfg_red_next  in  STATE_W  red-path next state
- cfg_blue_next  in  STATE_W  blue-path next state
- cfg_red_inv  in  1  red-path invert flag
- cfg_blue_inv  in  1  blue-path invert flag
- cfg_start  in  1  arm the machine; clears run state
- cfg_err  out  1  sticky bad-config flag
- mode  in  1  0=encrypt, 1=decrypt; sampled only at cfg_start
- running  out  1  high in RUN
- in_valid  in  1  input bit valid
- in_ready  out  1  input accepted when in_valid&&in_ready
- in_data  in  1  plaintext (enc) or ciphertext (dec)
- out_valid  out  1  output register holds a bit
- out_ready  in  1  downstream accepts
- out_data  out  1  ciphertext (enc) or plaintext (dec)
- dbg_state  out  STATE_W  current state
- dbg_path_select  out  1  current path register

Behaviour:
- Reset (rst_n=0 at a posedge):
  - FSM=CONFIG; state=0; hist=0; path_sel=0; mode_r=0.
  - Tables: red_next[i]=blue_next[i]=(i+1) mod NUM_STATES; all invert flags 0.
  - Outputs: cfg_err=0, running=0, in_ready=0, out_valid=0, out_data=0.
- FSM has two states, CONFIG and RUN.
- CONFIG:
  - cfg_we writes entry cfg_addr.
  - If cfg_addr, cfg_red_next or cfg_blue_next is >= NUM_STATES, the write is dropped and cfg_err is set.
  - cfg_start -> RUN next cycle: state=0, hist=0, path_sel=0, out_valid=0, cfg_err cleared, mode_r<=mode.
- RUN:
  - cfg_we in RUN returns the FSM to CONFIG and performs the write.
  - Any in-flight out_valid is dropped, and in_ready falls the next cycle.
  - cfg_start in RUN restarts as from CONFIG.
  - cfg_start and cfg_we in the same cycle: the write is performed first, then RUN is entered with the new table.
- Combinational in_ready = running && (!out_valid || out_ready).
- Per accepted bit b (in_valid && in_ready):
  - p=path_sel, s=state.
  - key = hist[s] ^ (p ? red_inv[s] : blue_inv[s]).
  - o = b ^ key.
  - fb = mode_r ? b : o, i.e. feedback is always the ciphertext.
  - Registered updates: state <= p ? red_next[s] : blue_next[s]; hist <= {hist[HIST_DEPTH-2:0], fb}; path_sel <= fb; out_data <= o; out_valid <= 1.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one bit per cycle under continuous out_ready.
- Output register:
  - out_valid clears when out_ready is high and no new bit is accepted in that cycle.
  - When a bit is accepted while the old bit drains, out_valid stays high with the new data.
  - With out_ready low and out_valid high, the output holds and in_ready=0; no bit is ever lost or duplicated.
- State wrap: next state comes only from the table, so no implicit wrap. Table entries are range-checked at write time, so the state never exceeds NUM_STATES-1.
- in_valid is ignored in CONFIG.
- Reset asserted mid-stream: all registers return to reset values on that edge, including the tables.

Test Plan:
- Default tables, NUM_STATES=8, encrypt, 10 zero bits with out_ready=1 -> out_data all 0; dbg_state 0,1,...,7,0,1; out_valid 1 cycle after each accept.
- All invert flags set to 1, encrypt, in_data=0 -> first out_data=1, second out_data=1 (hist[1]=0); dbg_path_select=1 after the first accept.
- Random tables, encrypt 256 random bits; reload the same tables with mode=1 and decrypt the produced ciphertext -> output equals the original plaintext bit-for-bit.
- Decrypt with the first 8 ciphertext bits corrupted -> plaintext matches again from the bit whose history window (HIST_DEPTH bits) and path have resynchronised. The check assumes state resync, so use the identity ring table.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly one bit accepted, in_ready=0, out_data stable; on release, no loss or duplication.
- cfg_we with cfg_addr=9 (NUM_STATES=8) -> cfg_err=1 and the table is unchanged. cfg_start -> cfg_err=0. rst_n=0 mid-stream -> out_valid=0, running=0 and dbg_state=0 on the next cycle.

Source files
------------

// File: rtl/nash_core_xp.sv
// nash_core_xp: two-path (red/blue) Nash-style keystream machine with a
// configurable state count and history depth. Tables are loaded one entry at
// a time; the keystream is XORed with a bit stream. Ciphertext feedback makes
// decryption self-synchronising. The output is registered and uses a
// valid/ready handshake.
module nash_core_xp #(
  parameter int NUM_STATES = 8,
  parameter int STATE_W    = 4,
  parameter int HIST_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0] cfg_red_next,
  input  logic [STATE_W-1:0] cfg_blue_next,
  input  logic               cfg_red_inv,
  input  logic               cfg_blue_inv,
  input  logic               cfg_start,
  output logic               cfg_err,
  input  logic               mode,
  output logic               running,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_data,
  output logic [STATE_W-1:0] dbg_state,
  output logic               dbg_path_select
);

  // Lookups are done over the full 2^STATE_W index range so that indexing with
  // a state value never needs a width change; rows past NUM_STATES read zero.
  localparam int TAB_N = 1 << STATE_W;
  localparam logic [STATE_W:0] NS_LIM = (STATE_W + 1)'(NUM_STATES);

  typedef enum logic {
    ST_CONFIG = 1'b0,
    ST_RUN    = 1'b1
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [STATE_W-1:0]    state_q, state_d;
  logic [HIST_DEPTH-1:0] hist_q, hist_d;
  logic                  path_q, path_d;
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_data_q, out_data_d;

  logic [STATE_W-1:0]    red_tab  [TAB_N];
  logic [STATE_W-1:0]    blue_tab [TAB_N];
  logic [TAB_N-1:0]      red_inv_tab;
  logic [TAB_N-1:0]      blue_inv_tab;
  logic [TAB_N-1:0]      hist_win;

  logic                  cfg_bad;
  logic                  tab_we;
  logic                  accept;
  logic                  key_bit;
  logic                  out_bit;
  logic                  fb_bit;

  // Any out-of-range index or next-state makes the whole write invalid, so the
  // machine can never be steered outside 0..NUM_STATES-1.
  assign cfg_bad = ({1'b0, cfg_addr} >= NS_LIM) ||
                   ({1'b0, cfg_red_next} >= NS_LIM) ||
                   ({1'b0, cfg_blue_next} >= NS_LIM);
  assign tab_we  = cfg_we && !cfg_bad;

  genvar gi;
  generate
    for (gi = 0; gi < TAB_N; gi++) begin : g_tab
      if (gi < NUM_STATES) begin : g_live
        localparam logic [STATE_W-1:0] RST_NEXT = STATE_W'((gi + 1) % NUM_STATES);
        logic [STATE_W-1:0] red_q;
        logic [STATE_W-1:0] blue_q;
        logic               red_inv_q;
        logic               blue_inv_q;

        // Table entry: identity ring after reset, replaced by a valid config write
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            red_q      <= RST_NEXT;
            blue_q     <= RST_NEXT;
            red_inv_q  <= 1'b0;
            blue_inv_q <= 1'b0;
          end else if (tab_we && (cfg_addr == STATE_W'(gi))) begin
            red_q      <= cfg_red_next;
            blue_q     <= cfg_blue_next;
            red_inv_q  <= cfg_red_inv;
            blue_inv_q <= cfg_blue_inv;
          end
        end

        assign red_tab[gi]      = red_q;
        assign blue_tab[gi]     = blue_q;
        assign red_inv_tab[gi]  = red_inv_q;
        assign blue_inv_tab[gi] = blue_inv_q;
        // Only the first NUM_STATES history taps can ever be selected as key.
        assign hist_win[gi]     = hist_q[gi];
      end else begin : g_pad
        assign red_tab[gi]      = '0;
        assign blue_tab[gi]     = '0;
        assign red_inv_tab[gi]  = 1'b0;
        assign blue_inv_tab[gi] = 1'b0;
        assign hist_win[gi]     = 1'b0;
      end
    end
  endgenerate

  // The output slot frees up in the same cycle it is drained.
  assign in_ready = (fsm_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Key is the history tap picked by the current state, optionally inverted by
  // the flag belonging to the currently selected path.
  assign key_bit = hist_win[state_q] ^
                   (path_q ? red_inv_tab[state_q] : blue_inv_tab[state_q]);
  assign out_bit = in_data ^ key_bit;
  // Feedback is always the ciphertext: the input when decrypting, the output
  // when encrypting. This is what lets a decryptor recover after bit errors.
  assign fb_bit  = mode_q ? in_data : out_bit;

  // Next-state logic: config actions take priority over the data path
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    hist_d      = hist_q;
    path_d      = path_q;
    mode_d      = mode_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (cfg_we && cfg_bad) begin
      err_d = 1'b1;
    end

    if (cfg_start) begin
      // A simultaneous write has already been applied to the table this edge,
      // so the machine starts with the new entry.
      fsm_d       = ST_RUN;
      state_d     = '0;
      hist_d      = '0;
      path_d      = 1'b0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      mode_d      = mode;
    end else if (cfg_we) begin
      fsm_d       = ST_CONFIG;
      out_valid_d = 1'b0;
    end else if (accept) begin
      state_d     = path_q ? red_tab[state_q] : blue_tab[state_q];
      hist_d      = {hist_q[HIST_DEPTH-2:0], fb_bit};
      path_d      = fb_bit;
      out_data_d  = out_bit;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register for the FSM, cipher state and output slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= ST_CONFIG;
      state_q     <= '0;
      hist_q      <= '0;
      path_q      <= 1'b0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      hist_q      <= hist_d;
      path_q      <= path_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_err         = err_q;
  assign running         = (fsm_q == ST_RUN);
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign dbg_state       = state_q;
  assign dbg_path_select = path_q;

endmodule

// File: tb/tb_nash_core_xp.sv
// Testbench for nash_core_xp: directed stimulus, scoreboard queue checked by
// an independent output monitor.
module tb_nash_core_xp;
  localparam int NS = 8;
  localparam int SW = 4;
  localparam int HD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [SW-1:0] cfg_red_next;
  logic [SW-1:0] cfg_blue_next;
  logic          cfg_red_inv;
  logic          cfg_blue_inv;
  logic          cfg_start;
  logic          cfg_err;
  logic          mode;
  logic          running;
  logic          in_valid;
  logic          in_ready;
  logic          in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_data;
  logic [SW-1:0] dbg_state;
  logic          dbg_path_select;

  nash_core_xp #(.NUM_STATES(NS), .STATE_W(SW), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_red_next(cfg_red_next),
    .cfg_blue_next(cfg_blue_next), .cfg_red_inv(cfg_red_inv),
    .cfg_blue_inv(cfg_blue_inv), .cfg_start(cfg_start), .cfg_err(cfg_err),
    .mode(mode), .running(running),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state), .dbg_path_select(dbg_path_select)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic exp;
    logic chk;
  } sb_t;
  sb_t sb[$];
  int  out_count = 0;

  // Reference model of the cipher
  int            m_red  [NS];
  int            m_blue [NS];
  bit            m_rinv [NS];
  bit            m_binv [NS];
  int            m_state;
  logic [HD-1:0] m_hist;
  bit            m_path;
  bit            m_mode;

  bit pt [256];
  bit ct [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bit model_step(input bit b);
    bit key, o, fb;
    key = m_hist[m_state] ^ (m_path ? m_rinv[m_state] : m_binv[m_state]);
    o = b ^ key;
    fb = m_mode ? b : o;
    m_state = m_path ? m_red[m_state] : m_blue[m_state];
    m_hist = {m_hist[HD-2:0], fb};
    m_path = fb;
    return o;
  endfunction

  task automatic model_default();
    for (int i = 0; i < NS; i++) begin
      m_red[i] = (i + 1) % NS;
      m_blue[i] = (i + 1) % NS;
      m_rinv[i] = 1'b0;
      m_binv[i] = 1'b0;
    end
    m_state = 0; m_hist = '0; m_path = 1'b0; m_mode = 1'b0;
  endtask

  // Output monitor: every bit handed downstream is checked against the queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: out_data=%0b presented with no bit outstanding", out_data);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.chk) check($sformatf("sb_out_data[%0d]", out_count), {31'd0, out_data}, {31'd0, e.exp});
        out_count++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    model_default();
  endtask

  task automatic cfg_write(input int a, input int r, input int bl, input bit ri, input bit bi);
    cfg_we = 1'b1;
    cfg_addr = SW'(a); cfg_red_next = SW'(r); cfg_blue_next = SW'(bl);
    cfg_red_inv = ri; cfg_blue_inv = bi;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < NS && r < NS && bl < NS) begin
      m_red[a] = r; m_blue[a] = bl; m_rinv[a] = ri; m_binv[a] = bi;
    end
  endtask

  task automatic start(input bit md);
    cfg_start = 1'b1;
    mode = md;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    m_state = 0; m_hist = '0; m_path = 1'b0; m_mode = md;
  endtask

  task automatic send(input bit b, input bit e, input bit c);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp: e, chk: c});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("drain_queue_empty", sb.size(), 0);
    check("drain_out_valid", {31'd0, out_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e0, b1, hold;
    bit pt2 [32];
    bit ct2 [32];

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_red_next = '0; cfg_blue_next = '0;
    cfg_red_inv = 1'b0; cfg_blue_inv = 1'b0; cfg_start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    model_default();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_running", {31'd0, running}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_cfg_err", {31'd0, cfg_err}, 0);
    check("rst_out_data", {31'd0, out_data}, 0);
    check("rst_dbg_state", {28'd0, dbg_state}, 0);
    check("rst_dbg_path", {31'd0, dbg_path_select}, 0);

    // in_valid is ignored in CONFIG
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("config_ignores_input", {31'd0, out_valid}, 0);

    // Default ring, all-zero plaintext: zero keystream, states walk 0..7,0,1
    start(1'b0);
    check("start_running", {31'd0, running}, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ring_dbg_state[%0d]", i), {28'd0, dbg_state}, i % NS);
      send(1'b0, 1'b0, 1'b1);
      check($sformatf("ring_latency_valid[%0d]", i), {31'd0, out_valid}, 1);
    end
    drain();

    // All invert flags set: first key 1, second key hist[1]^1 = 1
    for (int i = 0; i < NS; i++) cfg_write(i, (i + 1) % NS, (i + 1) % NS, 1'b1, 1'b1);
    start(1'b0);
    send(1'b0, 1'b1, 1'b1);
    check("inv_path_select", {31'd0, dbg_path_select}, 1);
    send(1'b0, 1'b1, 1'b1);
    drain();

    // Random tables: encrypt 256 bits, then decrypt back to plaintext
    for (int i = 0; i < NS; i++)
      cfg_write(i, $urandom_range(0, NS - 1), $urandom_range(0, NS - 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    start(1'b0);
    for (int i = 0; i < 256; i++) begin
      pt[i] = 1'($urandom_range(0, 1));
      ct[i] = model_step(pt[i]);
      send(pt[i], ct[i], 1'b1);
    end
    drain();
    start(1'b1);
    for (int i = 0; i < 256; i++) send(ct[i], pt[i], 1'b1);
    drain();

    // Backpressure: one bit held for 5 cycles, nothing else accepted
    start(1'b0);
    out_ready = 1'b0;
    e0 = model_step(1'b1);
    send(1'b1, e0, 1'b1);
    b1 = 1'b0;
    hold = e0;
    in_valid = 1'b1;
    in_data = b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready[%0d]", c), {31'd0, in_ready}, 0);
      check($sformatf("bp_out_data[%0d]", c), {31'd0, out_data}, {31'd0, hold});
      @(posedge clk); #1;
    end
    check("bp_one_accept_state", {28'd0, dbg_state}, m_state);
    out_ready = 1'b1;
    send(b1, model_step(b1), 1'b1);
    for (int i = 0; i < 6; i++) send(1'(i & 1), model_step(1'(i & 1)), 1'b1);
    drain();

    // Self-synchronisation on the identity ring after corrupted ciphertext
    do_reset();
    for (int i = 0; i < 32; i++) begin
      pt2[i] = 1'($urandom_range(0, 1));
      ct2[i] = model_step(pt2[i]);
    end
    for (int i = 0; i < 8; i++) ct2[i] = ~ct2[i];
    start(1'b1);
    for (int i = 0; i < 32; i++) send(ct2[i], pt2[i], (i >= 16));
    drain();

    // Bad config writes are dropped and flagged
    cfg_write(9, 0, 0, 1'b0, 1'b0);
    check("err_addr_set", {31'd0, cfg_err}, 1);
    check("err_write_leaves_run", {31'd0, running}, 0);
    start(1'b0);
    check("err_cleared_by_start", {31'd0, cfg_err}, 0);
    cfg_write(1, 9, 9, 1'b1, 1'b1);
    check("err_next_set", {31'd0, cfg_err}, 1);
    start(1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("err_table_kept_state[%0d]", i), {28'd0, dbg_state}, i);
      send(1'b0, model_step(1'b0), 1'b1);
    end
    drain();

    // Reset in the middle of a stream
    start(1'b0);
    for (int i = 0; i < 3; i++) send(1'b1, model_step(1'b1), 1'b1);
    out_ready = 1'b0;
    check("mid_pre_out_valid", {31'd0, out_valid}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    model_default();
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_running", {31'd0, running}, 0);
    check("mid_rst_dbg_state", {28'd0, dbg_state}, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
